// File: rtl/sprite_row_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_row_fetch_arbiter
//
// Purpose:
//   Two sprite draw units (player 1 = req[0], player 2 = req[1]) share one
//   sprite frame RAM. A round-robin arbiter grants one row request. The block
//   then issues SPRITE_W consecutive RAM reads starting at
//   base + row*SPRITE_W. It streams the returned pixels to the winner's line
//   buffer as a contiguous, ascending run of column writes.
//
// Ports:
//   Clk        in   clock, all state updates on the rising edge
//   Reset      in   asynchronous, active-high reset
//   req[1:0]   in   level row request per requester, held until ack
//   row0/row1  in   sprite row per requester, sampled at grant
//   base0/base1 in  sprite base address per requester, sampled at grant
//   ack[1:0]   out  one-cycle one-hot grant pulse
//   busy       out  fetch in progress
//   rom_addr   out  registered frame RAM read address
//   rom_data   in   frame RAM read data, valid one cycle after rom_addr
//   pix_we     out  registered line-buffer write strobe
//   pix_col    out  column being written
//   pix_data   out  pixel value (registered copy of rom_data)
//   pix_owner  out  requester index of the current write
//   done[1:0]  out  one-cycle one-hot pulse coincident with the final write
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for a request; arbitrates and latches the fetch
//   S_ISSUE  | presenting addr0 .. addr0+SPRITE_W-1, one per cycle
//   S_DRAIN  | two cycles letting the RAM and pixel stages empty
// ---------------------------------------------------------------------------
module sprite_row_fetch_arbiter #(
    parameter int SPRITE_W = 16,
    parameter int ROW_W    = 4,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 24,
    localparam int COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [ROW_W-1:0]  row0,
    input  logic [ROW_W-1:0]  row1,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    output logic [1:0]        ack,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pix_we,
    output logic [COL_W-1:0]  pix_col,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_owner,
    output logic [1:0]        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(SPRITE_W - 1);
    localparam logic [COL_W-1:0] DRAIN_LAST = COL_W'(1);

    // Control state
    logic [1:0]        state_q,    state_d;
    logic [COL_W-1:0]  cnt_q,      cnt_d;
    logic              owner_q,    owner_d;
    logic              rr_q,       rr_d;       // index of last granted requester
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]        ack_q,      ack_d;
    logic              busy_q,     busy_d;

    // Read-return tracking: marks the cycle in which rom_data belongs to us
    logic              rd_vld_q,   rd_vld_d;
    logic [COL_W-1:0]  rd_col_q,   rd_col_d;

    // Pixel output stage
    logic              pix_we_q,    pix_we_d;
    logic [COL_W-1:0]  pix_col_q,   pix_col_d;
    logic [DATA_W-1:0] pix_data_q,  pix_data_d;
    logic              pix_owner_q, pix_owner_d;
    logic [1:0]        done_q,      done_d;

    // Start address of each requester's row, truncated to the RAM address space
    logic [ADDR_W-1:0] start0, start1;
    logic              grant_idx;

    assign start0 = base0 + ADDR_W'(row0) * ADDR_W'(SPRITE_W);
    assign start1 = base1 + ADDR_W'(row1) * ADDR_W'(SPRITE_W);

    // Both requesting: the one not granted last time wins. Single requester:
    // req[1] alone selects 1, req[0] alone selects 0.
    always_comb begin
        grant_idx = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~rr_q;
        end else begin
            grant_idx = req[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        rom_addr_d = rom_addr_q;
        ack_d      = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d    = grant_idx;
                    rr_d       = grant_idx;
                    ack_d      = grant_idx ? 2'b10 : 2'b01;
                    rom_addr_d = grant_idx ? start1 : start0;
                    cnt_d      = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == LAST_COL) begin
                    // rom_addr holds the last column address from here on
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d      = cnt_q + COL_W'(1);
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + COL_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // The RAM answers one cycle after an address is presented, so an address
    // shown while in S_ISSUE yields data in the following cycle. The pixel
    // stage registers that data one more edge later.
    always_comb begin
        rd_vld_d = (state_q == S_ISSUE);
        rd_col_d = cnt_q;

        pix_we_d    = rd_vld_q;
        pix_col_d   = pix_col_q;
        pix_data_d  = pix_data_q;
        pix_owner_d = pix_owner_q;
        done_d      = 2'b00;

        if (rd_vld_q) begin
            pix_col_d   = rd_col_q;
            pix_data_d  = rom_data;
            pix_owner_d = owner_q;
            if (rd_col_q == LAST_COL) begin
                done_d = owner_q ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b1;
            rom_addr_q  <= '0;
            ack_q       <= 2'b00;
            busy_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_col_q    <= '0;
            pix_we_q    <= 1'b0;
            pix_col_q   <= '0;
            pix_data_q  <= '0;
            pix_owner_q <= 1'b0;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            rom_addr_q  <= rom_addr_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            rd_vld_q    <= rd_vld_d;
            rd_col_q    <= rd_col_d;
            pix_we_q    <= pix_we_d;
            pix_col_q   <= pix_col_d;
            pix_data_q  <= pix_data_d;
            pix_owner_q <= pix_owner_d;
            done_q      <= done_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign rom_addr  = rom_addr_q;
    assign pix_we    = pix_we_q;
    assign pix_col   = pix_col_q;
    assign pix_data  = pix_data_q;
    assign pix_owner = pix_owner_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_row_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_row_fetch_arbiter
//
// Purpose:
//   Self-checking bench for sprite_row_fetch_arbiter. It contains a behavioural
//   frame RAM with a one-cycle registered read, a table of single-requester
//   fetches, and hand-written sequences for arbitration, reset and
//   mid-fetch corner cases.
// ---------------------------------------------------------------------------
module tb_sprite_row_fetch_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  req;
    logic [3:0]  row0, row1;
    logic [18:0] base0, base1;
    logic [1:0]  ack;
    logic        busy;
    logic [18:0] rom_addr;
    logic [23:0] rom_data;
    logic        pix_we;
    logic [3:0]  pix_col;
    logic [23:0] pix_data;
    logic        pix_owner;
    logic [1:0]  done;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    sprite_row_fetch_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .row0      (row0),
        .row1      (row1),
        .base0     (base0),
        .base1     (base1),
        .ack       (ack),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_we    (pix_we),
        .pix_col   (pix_col),
        .pix_data  (pix_data),
        .pix_owner (pix_owner),
        .done      (done)
    );

    // Frame RAM contents: a fixed function of the address
    function automatic logic [23:0] mem_word(input logic [18:0] a);
        return {a[7:0] ^ 8'h5A, a[18:8], 5'h13};
    endfunction

    always @(posedge Clk) rom_data <= mem_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack expected an ack within 40 cycles");
        end
    endtask

    // Called at the sample point just after the grant edge E0. Checks every
    // cycle up to E0+18, when the block must be idle again.
    task automatic check_fetch(input logic owner, input logic [18:0] addr0,
                               input bit hold, input bit mutate, input logic [1:0] raise);
        logic [1:0]  oh;
        logic [18:0] ea;
        oh = owner ? 2'b10 : 2'b01;
        for (int t = 0; t <= 18; t++) begin
            if (t > 0) begin
                @(posedge Clk); #1;
            end
            ea = addr0 + 19'((t > 15) ? 15 : t);
            check("ack", 32'(ack), (t == 0) ? 32'(oh) : 32'd0);
            check("busy", 32'(busy), 32'(t <= 17));
            check("rom_addr", 32'(rom_addr), 32'(ea));
            check("pix_we", 32'(pix_we), 32'(t >= 2 && t <= 17));
            if (t >= 2 && t <= 17) begin
                check("pix_col", 32'(pix_col), 32'(t - 2));
                check("pix_data", 32'(pix_data), 32'(mem_word(addr0 + 19'(t - 2))));
                check("pix_owner", 32'(pix_owner), 32'(owner));
            end
            check("done", 32'(done), (t == 17) ? 32'(oh) : 32'd0);
            if (t == 0 && !hold) req[owner] = 1'b0;
            if (t == 5) req = req | raise;
            if (mutate) begin
                row0  = 4'($urandom);
                row1  = 4'($urandom);
                base0 = 19'($urandom);
                base1 = 19'($urandom);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [3:0]  row0;
        logic [18:0] base0;
        logic [3:0]  row1;
        logic [18:0] base1;
        logic        owner;
        logic [18:0] addr0;
    } vec_t;

    vec_t vecs[4];

    initial begin
        bit ok;

        vecs[0] = '{req: 2'b01, row0: 4'd3,  base0: 19'h00000, row1: 4'd0, base1: 19'h0, owner: 1'b0, addr0: 19'h00030};
        vecs[1] = '{req: 2'b10, row0: 4'd0,  base0: 19'h0, row1: 4'd5,  base1: 19'h01000, owner: 1'b1, addr0: 19'h01050};
        vecs[2] = '{req: 2'b01, row0: 4'd0,  base0: 19'h7FFF8, row1: 4'd0, base1: 19'h0, owner: 1'b0, addr0: 19'h7FFF8};
        vecs[3] = '{req: 2'b10, row0: 4'd0,  base0: 19'h0, row1: 4'd15, base1: 19'h7FFF0, owner: 1'b1, addr0: 19'h000E0};

        Reset = 1'b1;
        req   = 2'b00;
        row0  = '0;
        row1  = '0;
        base0 = '0;
        base1 = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_pix", 32'({pix_we, pix_col, pix_data, pix_owner}), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        Reset = 1'b0;

        // Single-requester fetches, including address wrap
        for (int i = 0; i < 4; i++) begin
            row0  = vecs[i].row0;
            base0 = vecs[i].base0;
            row1  = vecs[i].row1;
            base1 = vecs[i].base1;
            req   = vecs[i].req;
            wait_ack(ok);
            if (ok) check_fetch(vecs[i].owner, vecs[i].addr0, 1'b0, 1'b0, 2'b00);
        end

        // Both held after reset: strict alternation at 19-cycle spacing
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        row0 = 4'd1; base0 = 19'h00100;
        row1 = 4'd2; base1 = 19'h00200;
        req  = 2'b11;
        wait_ack(ok);
        if (ok) begin
            check_fetch(1'b0, 19'h00110, 1'b1, 1'b0, 2'b00);
            @(posedge Clk); #1;
            check_fetch(1'b1, 19'h00220, 1'b1, 1'b0, 2'b00);
            @(posedge Clk); #1;
            check_fetch(1'b0, 19'h00110, 1'b1, 1'b0, 2'b00);
        end
        req = 2'b00;

        // req[1] rises mid-fetch, req[0] dropped after ack
        row0 = 4'd4; base0 = 19'h00000;
        row1 = 4'd7; base1 = 19'h03000;
        req  = 2'b01;
        wait_ack(ok);
        if (ok) begin
            check_fetch(1'b0, 19'h00040, 1'b0, 1'b0, 2'b10);
            @(posedge Clk); #1;
            check_fetch(1'b1, 19'h03070, 1'b0, 1'b0, 2'b00);
        end

        // row/base churn during a fetch
        row1 = 4'd9; base1 = 19'h40000;
        req  = 2'b10;
        wait_ack(ok);
        if (ok) check_fetch(1'b1, 19'h40090, 1'b0, 1'b1, 2'b00);

        // Reset after column 5 is written, req kept high
        req  = 2'b00;
        row0 = 4'd2; base0 = 19'h00000;
        row1 = 4'd0; base1 = 19'h00000;
        req  = 2'b01;
        wait_ack(ok);
        if (ok) begin
            repeat (7) @(posedge Clk);
            #1;
            check("pre_rst_we", 32'(pix_we), 32'd1);
            check("pre_rst_col", 32'(pix_col), 32'd5);
            Reset = 1'b1;
            #1;
            check("rst_ack_busy", 32'({ack, busy}), 32'd0);
            check("rst_addr", 32'(rom_addr), 32'd0);
            check("rst_pix", 32'({pix_we, pix_col, pix_owner}), 32'd0);
            check("rst_data", 32'(pix_data), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            @(posedge Clk); #1;
            check("rst_hold_done", 32'(done), 32'd0);
            Reset = 1'b0;
            wait_ack(ok);
            if (ok) check_fetch(1'b0, 19'h00020, 1'b0, 1'b0, 2'b00);
        end

        req = 2'b00;
        @(posedge Clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
